// File: rtl/soc_membus_arbiter.sv
// Two-master arbiter for one shared memory slave.
// Registered grant, alternating tie-break, per-transaction timeout.
module soc_membus_arbiter #(
    parameter int ADDR_WIDTH = 32,
    parameter int TIMEOUT    = 64
) (
    input  logic                  clk,
    input  logic                  res,
    input  logic                  m0_req,
    input  logic [ADDR_WIDTH-1:0] m0_addr,
    input  logic [31:0]           m0_wdata,
    input  logic [3:0]            m0_wstrb,
    output logic                  m0_ready,
    output logic [31:0]           m0_rdata,
    output logic                  m0_err,
    input  logic                  m1_req,
    input  logic [ADDR_WIDTH-1:0] m1_addr,
    input  logic [31:0]           m1_wdata,
    input  logic [3:0]            m1_wstrb,
    output logic                  m1_ready,
    output logic [31:0]           m1_rdata,
    output logic                  m1_err,
    output logic                  s_req,
    output logic [ADDR_WIDTH-1:0] s_addr,
    output logic [31:0]           s_wdata,
    output logic [3:0]            s_wstrb,
    input  logic                  s_ready,
    input  logic [31:0]           s_rdata,
    output logic [1:0]            grant
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BUSY0 = 2'd1,
        BUSY1 = 2'd2
    } state_t;

    localparam logic [15:0] CNT_MAX = 16'(TIMEOUT - 1);

    state_t      state;
    state_t      state_n;
    logic        last;
    logic        last_n;
    logic [15:0] cnt;
    logic        expire;

    assign expire = (cnt == CNT_MAX);

    // State and last-served master registers.
    always_ff @(posedge clk or negedge res) begin
        if (!res) begin
            state <= IDLE;
            last  <= 1'b1;
        end else begin
            state <= state_n;
            last  <= last_n;
        end
    end

    // Timeout counter: restarts on every new grant, ages while waiting.
    always_ff @(posedge clk or negedge res) begin
        if (!res) begin
            cnt <= 16'd0;
        end else if (state_n != state) begin
            cnt <= 16'd0;
        end else if (state != IDLE) begin
            cnt <= cnt + 16'd1;
        end
    end

    // Arbitration, slave forwarding and completion/timeout responses.
    always_comb begin
        state_n  = state;
        last_n   = last;
        grant    = 2'b00;
        s_req    = 1'b0;
        s_addr   = '0;
        s_wdata  = '0;
        s_wstrb  = '0;
        m0_ready = 1'b0;
        m0_rdata = '0;
        m0_err   = 1'b0;
        m1_ready = 1'b0;
        m1_rdata = '0;
        m1_err   = 1'b0;
        unique case (state)
            IDLE: begin
                if (m0_req && m1_req) begin
                    state_n = last ? BUSY0 : BUSY1;
                end else if (m0_req) begin
                    state_n = BUSY0;
                end else if (m1_req) begin
                    state_n = BUSY1;
                end
            end
            BUSY0: begin
                grant   = 2'b01;
                s_req   = 1'b1;
                s_addr  = m0_addr;
                s_wdata = m0_wdata;
                s_wstrb = m0_wstrb;
                if (s_ready || expire) begin
                    m0_ready = 1'b1;
                    m0_rdata = s_ready ? s_rdata : 32'd0;
                    m0_err   = !s_ready;
                    last_n   = 1'b0;
                    state_n  = m1_req ? BUSY1 : IDLE;
                end
            end
            BUSY1: begin
                grant   = 2'b10;
                s_req   = 1'b1;
                s_addr  = m1_addr;
                s_wdata = m1_wdata;
                s_wstrb = m1_wstrb;
                if (s_ready || expire) begin
                    m1_ready = 1'b1;
                    m1_rdata = s_ready ? s_rdata : 32'd0;
                    m1_err   = !s_ready;
                    last_n   = 1'b1;
                    state_n  = m0_req ? BUSY0 : IDLE;
                end
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_soc_membus_arbiter.sv
// Bench for soc_membus_arbiter: directed table, corner sequences,
// and random traffic against a transaction-level reference model.
module tb_soc_membus_arbiter;

    localparam int TO = 4;

    logic        clk = 1'b0;
    logic        res;
    logic        m0_req, m1_req;
    logic [31:0] m0_addr, m0_wdata, m1_addr, m1_wdata;
    logic [3:0]  m0_wstrb, m1_wstrb;
    logic        m0_ready, m0_err, m1_ready, m1_err;
    logic [31:0] m0_rdata, m1_rdata;
    logic        s_req, s_ready;
    logic [31:0] s_addr, s_wdata, s_rdata;
    logic [3:0]  s_wstrb;
    logic [1:0]  grant;

    int n_pass = 0;
    int n_total = 0;

    soc_membus_arbiter #(.ADDR_WIDTH(32), .TIMEOUT(TO)) dut (
        .clk(clk), .res(res),
        .m0_req(m0_req), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
        .m0_wstrb(m0_wstrb), .m0_ready(m0_ready), .m0_rdata(m0_rdata),
        .m0_err(m0_err),
        .m1_req(m1_req), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
        .m1_wstrb(m1_wstrb), .m1_ready(m1_ready), .m1_rdata(m1_rdata),
        .m1_err(m1_err),
        .s_req(s_req), .s_addr(s_addr), .s_wdata(s_wdata),
        .s_wstrb(s_wstrb), .s_ready(s_ready), .s_rdata(s_rdata),
        .grant(grant)
    );

    always #5 clk = ~clk;

    function automatic logic [159:0] pack(
        logic [1:0] g, logic sr, logic [31:0] sa, logic [31:0] sd,
        logic [3:0] ss, logic r0, logic [31:0] d0, logic e0,
        logic r1, logic [31:0] d1, logic e1);
        return {21'd0, g, sr, sa, sd, ss, r0, d0, e0, r1, d1, e1};
    endfunction

    function automatic logic [159:0] outs();
        return pack(grant, s_req, s_addr, s_wdata, s_wstrb,
                    m0_ready, m0_rdata, m0_err,
                    m1_ready, m1_rdata, m1_err);
    endfunction

    task automatic chk(input string name, input logic [159:0] act,
                       input logic [159:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic drive(input logic r0, input logic [31:0] a0,
                         input logic [31:0] d0, input logic [3:0] s0,
                         input logic r1, input logic [31:0] a1,
                         input logic [31:0] d1, input logic [3:0] s1,
                         input logic sr, input logic [31:0] srd);
        m0_req = r0; m0_addr = a0; m0_wdata = d0; m0_wstrb = s0;
        m1_req = r1; m1_addr = a1; m1_wdata = d1; m1_wstrb = s1;
        s_ready = sr; s_rdata = srd;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        res = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        res = 1'b1;
    endtask

    typedef struct {
        logic        m0r;
        logic [31:0] m0a;
        logic        m1r;
        logic [31:0] m1a;
        logic [31:0] m1d;
        logic [3:0]  m1s;
        logic        sr;
        logic [31:0] srd;
        logic [159:0] exp;
    } vec_t;

    vec_t tbl[10];

    // random-phase model state
    int          owner;
    int          age;
    int          mlast;
    bit          pend[2];
    logic [31:0] ra[2];
    logic [31:0] rd[2];
    logic [3:0]  rs[2];

    initial begin
        logic [159:0] z;
        z = pack(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

        // ---------- reset state ----------
        res = 1'b0;
        drive(1, 32'h100, 0, 0, 1, 32'h40, 0, 0, 1, 32'h1234);
        #12;
        chk("reset_outputs", outs(), z);
        do_reset();

        // ---------- table: read, ignored ready, write, handover ----------
        tbl[0] = '{1'b1, 32'h100, 1'b0, 32'h0, 32'h0, 4'h0, 1'b0, 32'h0, z};
        tbl[1] = '{1'b1, 32'h100, 1'b0, 32'h0, 32'h0, 4'h0, 1'b0, 32'h0,
                   pack(1, 1, 32'h100, 0, 0, 0, 0, 0, 0, 0, 0)};
        tbl[2] = tbl[1];
        tbl[3] = '{1'b1, 32'h100, 1'b0, 32'h0, 32'h0, 4'h0, 1'b1,
                   32'hCAFEF00D,
                   pack(1, 1, 32'h100, 0, 0, 1, 32'hCAFEF00D, 0, 0, 0, 0)};
        tbl[4] = '{1'b0, 32'h0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b1,
                   32'hDEAD, z};
        tbl[5] = '{1'b0, 32'h0, 1'b1, 32'h40, 32'h12345678, 4'h3, 1'b0,
                   32'h0, z};
        tbl[6] = '{1'b1, 32'h200, 1'b1, 32'h40, 32'h12345678, 4'h3, 1'b0,
                   32'h0,
                   pack(2, 1, 32'h40, 32'h12345678, 3, 0, 0, 0, 0, 0, 0)};
        tbl[7] = '{1'b1, 32'h200, 1'b1, 32'h40, 32'h12345678, 4'h3, 1'b1,
                   32'h55,
                   pack(2, 1, 32'h40, 32'h12345678, 3, 0, 0, 0,
                        1, 32'h55, 0)};
        tbl[8] = '{1'b1, 32'h200, 1'b0, 32'h0, 32'h0, 4'h0, 1'b1, 32'h77,
                   pack(1, 1, 32'h200, 0, 0, 1, 32'h77, 0, 0, 0, 0)};
        tbl[9] = '{1'b0, 32'h0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b0, 32'h0, z};
        for (int i = 0; i < 10; i++) begin
            drive(tbl[i].m0r, tbl[i].m0a, 0, 0,
                  tbl[i].m1r, tbl[i].m1a, tbl[i].m1d, tbl[i].m1s,
                  tbl[i].sr, tbl[i].srd);
            @(negedge clk);
            chk($sformatf("table_%0d", i), outs(), tbl[i].exp);
            next_cycle();
        end

        // ---------- both held: alternate with no idle gap ----------
        do_reset();
        for (int i = 0; i < 5; i++) begin
            logic [1:0] g;
            logic [31:0] a;
            logic [31:0] d;
            d = 32'hA000 + 32'(i);
            drive(1, 32'h10, 0, 0, 1, 32'h20, 0, 0, 1, d);
            @(negedge clk);
            if (i == 0) begin
                chk("alt_idle", outs(), z);
            end else begin
                g = (i % 2 == 1) ? 2'b01 : 2'b10;
                a = g[0] ? 32'h10 : 32'h20;
                chk($sformatf("alt_%0d", i), outs(),
                    pack(g, 1, a, 0, 0, g[0], g[0] ? d : 32'd0, 0,
                         g[1], g[1] ? d : 32'd0, 0));
            end
            next_cycle();
        end

        // ---------- timeout (t=0) and ready on last cycle (t=1) ----------
        for (int t = 0; t < 2; t++) begin
            logic [31:0] a;
            a = (t == 0) ? 32'h300 : 32'h304;
            do_reset();
            for (int c = 0; c <= TO + 1; c++) begin
                logic sr;
                sr = (c == TO + 1) || (t == 1 && c == TO);
                drive(c <= TO, a, 0, 0, 0, 0, 0, 0, sr, 32'hABCD1234);
                @(negedge clk);
                if (c == 0 || c == TO + 1)
                    chk($sformatf("to%0d_c%0d", t, c), outs(), z);
                else if (c < TO)
                    chk($sformatf("to%0d_c%0d", t, c), outs(),
                        pack(1, 1, a, 0, 0, 0, 0, 0, 0, 0, 0));
                else if (t == 0)
                    chk("timeout_err", outs(),
                        pack(1, 1, a, 0, 0, 1, 0, 1, 0, 0, 0));
                else
                    chk("timeout_ready_wins", outs(),
                        pack(1, 1, a, 0, 0, 1, 32'hABCD1234, 0, 0, 0, 0));
                next_cycle();
            end
        end

        // ---------- asynchronous reset while BUSY1 ----------
        do_reset();
        drive(0, 0, 0, 0, 1, 32'h40, 32'h5, 4'hF, 0, 0);
        next_cycle();
        @(negedge clk);
        chk("busy1_before_reset", outs(),
            pack(2, 1, 32'h40, 32'h5, 4'hF, 0, 0, 0, 0, 0, 0));
        s_ready = 1'b1;
        s_rdata = 32'h99;
        #1;
        res = 1'b0;
        #1;
        chk("async_reset_zero", outs(), z);
        drive(1, 32'h80, 0, 0, 1, 32'h90, 0, 0, 0, 0);
        next_cycle();
        res = 1'b1;
        @(negedge clk);
        chk("post_reset_idle", outs(), z);
        next_cycle();
        @(negedge clk);
        chk("post_reset_m0_first", outs(),
            pack(1, 1, 32'h80, 0, 0, 0, 0, 0, 0, 0, 0));
        next_cycle();

        // ---------- random traffic vs. transaction model ----------
        do_reset();
        owner = -1;
        age = 0;
        mlast = 1;
        pend[0] = 0;
        pend[1] = 0;
        for (int n = 0; n < 1500; n++) begin
            logic        sr;
            logic [31:0] srd;
            logic        done;
            logic [1:0]  g;
            logic [31:0] ea, ed, rv;
            logic [3:0]  es;
            logic [1:0]  rdy;
            for (int i = 0; i < 2; i++) begin
                if (!pend[i] && $urandom_range(0, 2) == 0) begin
                    pend[i] = 1;
                    ra[i] = $urandom;
                    rd[i] = $urandom;
                    rs[i] = 4'($urandom_range(0, 15));
                end
            end
            sr = ($urandom_range(0, 3) == 0);
            srd = $urandom;
            drive(pend[0], ra[0], rd[0], rs[0],
                  pend[1], ra[1], rd[1], rs[1], sr, srd);
            @(negedge clk);
            g = 0; ea = 0; ed = 0; es = 0; rdy = 0; rv = 0; done = 0;
            if (owner >= 0) begin
                g[owner] = 1'b1;
                ea = ra[owner];
                ed = rd[owner];
                es = rs[owner];
                done = sr || (age == TO - 1);
                rdy[owner] = done;
                rv = sr ? srd : 32'd0;
            end
            chk("rand", outs(),
                pack(g, owner >= 0, ea, ed, es,
                     rdy[0], rdy[0] ? rv : 32'd0, rdy[0] && !sr,
                     rdy[1], rdy[1] ? rv : 32'd0, rdy[1] && !sr));
            if (owner < 0) begin
                if (pend[0] && pend[1]) owner = 1 - mlast;
                else if (pend[0]) owner = 0;
                else if (pend[1]) owner = 1;
                age = 0;
            end else if (done) begin
                int o;
                o = 1 - owner;
                mlast = owner;
                pend[owner] = 0;
                owner = pend[o] ? o : -1;
                age = 0;
            end else begin
                age++;
            end
            next_cycle();
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/soc_membus_arbiter.md
SOC_MEMBUS_ARBITER -- requirements
Module: soc_membus_arbiter

Interface
REQ-001 Parameter ADDR_WIDTH, default 32, byte address width on all ports.
REQ-002 Parameter TIMEOUT, default 64, max cycles in BUSY without slave ready; legal range 2..65535.
REQ-003 clk  in  1  single clock; all state changes on rising edge.
REQ-004 res  in  1  reset, asynchronous, active-low.
REQ-005 mN_req  in  1  master N (N=0,1) request; held with addr/wdata/wstrb stable until mN_ready.
REQ-006 mN_addr  in  ADDR_WIDTH  master N byte address.
REQ-007 mN_wdata  in  32  master N write data.
REQ-008 mN_wstrb  in  4  master N byte write enables; 0 = read.
REQ-009 mN_ready  out  1  one-cycle completion pulse to master N.
REQ-010 mN_rdata  out  32  read data, valid only while mN_ready=1.
REQ-011 mN_err  out  1  timeout error, valid only while mN_ready=1.
REQ-012 s_req  out  1  request to shared memory slave.
REQ-013 s_addr / s_wdata / s_wstrb  out  ADDR_WIDTH / 32 / 4  forwarded from granted master.
REQ-014 s_ready  in  1  slave completion pulse.
REQ-015 s_rdata  in  32  slave read data, valid with s_ready.
REQ-016 grant  out  2  one-hot current owner; 00 in IDLE.

Function
REQ-017 FSM states: IDLE, BUSY0, BUSY1; plus register last (last-served master) and timeout counter cnt (16 bit).
REQ-018 IDLE: m0_req only -> BUSY0; m1_req only -> BUSY1; both -> BUSYk where k != last; none -> stay IDLE.
REQ-019 Grant registered: slave sees first s_req one cycle after the IDLE cycle sampling the request.
REQ-020 In BUSYk: s_req=1, s_addr/s_wdata/s_wstrb = mk_* combinationally; other master sees mN_ready=0.
REQ-021 Not BUSY: s_req=0, s_addr/s_wdata/s_wstrb=0.
REQ-022 In BUSYk with s_ready=1: mk_ready=1, mk_rdata=s_rdata, mk_err=0 same cycle (zero added latency); last<=k.
REQ-023 Completion transition: other master requesting that cycle -> BUSY(other) directly; else -> IDLE.
REQ-024 mN_rdata=0 and mN_err=0 whenever mN_ready=0.
REQ-025 cnt clears on entering any BUSY state; increments each BUSY cycle with s_ready=0.
REQ-026 Timeout: cnt == TIMEOUT-1 and s_ready=0 -> mk_ready=1, mk_err=1, mk_rdata=0; last<=k; next state per REQ-023.
REQ-027 s_ready=1 in timeout cycle -> normal completion wins, err=0.
REQ-028 s_ready while IDLE ignored; no master ready pulse.
REQ-029 Master dropping req before ready is a protocol violation; arbiter keeps grant until completion or timeout.
REQ-030 Late s_ready after timeout must not reach any master unless a new grant is active (then treated as that grant's completion).

Reset
REQ-031 res=0 asynchronously forces IDLE, last=1 (master 0 wins first tie), cnt=0, grant=00, s_req=0, all mN_ready/mN_err/mN_rdata=0, s_addr/s_wdata/s_wstrb=0.
REQ-032 Reset mid-transaction aborts it silently; no ready pulse to any master; first request after res=1 rearbitrates per REQ-018.

Verification
REQ-033 After reset, m0 read addr 0x100, slave ready 2 cycles after s_req with rdata 0xCAFEF00D -> m0_ready one cycle, m0_rdata=0xCAFEF00D, grant 01 then 00.
REQ-034 m0 and m1 request same cycle, both held continuously -> service order m0, m1, m0, m1; no IDLE cycle between grants.
REQ-035 m1 write addr 0x40 wdata 0x12345678 wstrb 0011 -> s_addr=0x40, s_wdata=0x12345678, s_wstrb=0011 while grant=10.
REQ-036 TIMEOUT=4, slave never ready -> m0_ready=1, m0_err=1, m0_rdata=0 on 4th BUSY0 cycle; s_req low next cycle; late s_ready ignored.
REQ-037 TIMEOUT=4, s_ready on 4th BUSY cycle -> normal completion, err=0.
REQ-038 res asserted while BUSY1 -> outputs zero immediately (asynchronous); after release, pending m0 and m1 -> m0 granted first.
